vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates raster timing for the 800x600@60 display path.
- Drives the pixel/line counters consumed by the downstream RGB pixel-fetch stage: count_rgb is the horizontal pixel index and reset_count_rgb is the line index. That stage upscales the 400x300 2-bit-per-channel image 2x.
- Also produces hsync/vsync for the connector, plus video_active, frame_start and pix_en qualifiers for other stages.

Parameters:
- CLK_DIV, 1: clk cycles per pixel (1 = clk is the pixel clock); >=1
- H_VIS, 800: visible pixels per line
- H_FP, 40: horizontal front porch
- H_SYNC, 128: hsync width
- H_BP, 88: horizontal back porch
- V_VIS, 600: visible lines
- V_FP, 1: vertical front porch
- V_SYNC, 4: vsync width
- V_BP, 23: vertical back porch
- HS_POL, 1: hsync active level
- VS_POL, 1: vsync active level

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- count_rgb  output  11  horizontal position, 0..H_TOT-1 (H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 1056)
- reset_count_rgb  output  10  vertical position, 0..V_TOT-1 (V_TOT = 628)
- hsync  output  1  horizontal sync, level per HS_POL
- vsync  output  1  vertical sync, level per VS_POL
- video_active  output  1  high when count_rgb<H_VIS and reset_count_rgb<V_VIS
- frame_start  output  1  one-tick pulse when the position output is (0,0)
- pix_en  output  1  high for the single clk cycle in which the outputs just updated

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_n); sampled on the rising edge of clk.
- Divider d counts 0..CLK_DIV-1 and wraps. tick = (d==CLK_DIV-1). With CLK_DIV=1, tick is constant 1.
- Internal next-position registers h_nxt (11b) and v_nxt (10b).
- On a clk edge with tick:
  - outputs load from (h_nxt, v_nxt) and their decode;
  - then h_nxt advances: h_nxt==H_TOT-1 -> 0 and v_nxt increments; v_nxt==V_TOT-1 on that wrap -> 0.
- Without tick, all position/sync/qualifier outputs hold. pix_en <= tick on every clk edge.
- Decode uses the value being loaded (position p = (h, v)):
  - hsync active iff H_VIS+H_FP <= h <= H_VIS+H_FP+H_SYNC-1 (840..967 default).
  - vsync active iff V_VIS+V_FP <= v <= V_VIS+V_FP+V_SYNC-1 (601..604 default).
  - vsync is a pure function of v; it changes only at line boundaries (h==0).
  - video_active = (h<H_VIS)&&(v<V_VIS).
  - frame_start = (h==0)&&(v==0), valid for one tick only.
- Output latency: zero cycles between the count outputs and their sync/active decode. All are registered together, so there is no skew.
- Reset (rst_n==0 at an edge) forces:
  - d=0, h_nxt=0, v_nxt=0;
  - count_rgb=0, reset_count_rgb=0;
  - hsync=~HS_POL, vsync=~VS_POL;
  - video_active=0, frame_start=0, pix_en=0.
- First tick after reset release: it occurs CLK_DIV edges after release. It loads (0,0) with video_active=1, frame_start=1, pix_en=1.
- Reset mid-frame aborts immediately, with no completion of the line or frame. Reset has priority over tick on the same edge.
- Arithmetic is unsigned. Counters never exceed H_TOT-1 / V_TOT-1. Widths are fixed at 11/10 bits; parameter sets must satisfy H_TOT<=2048 and V_TOT<=1024 (elaboration-time check).
- Wrap events coincide when h==H_TOT-1 and v==V_TOT-1. Both wrap on the same tick and the next loaded position is (0,0) with frame_start.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (H_VIS..V_BP, polarities);
  - derived H_TOT/V_TOT, the sync start/end functions;
  - width constants HCNT_W=11, VCNT_W=10.
- One natural sub-module: mod_counter (parameterised modulus, enable input, wrap output). It is instantiated for the divider, horizontal and vertical counters, with the vertical enable = horizontal wrap & tick.
- Sync/active decode stays inline.

Test Plan:
- Reset held 5 cycles, defaults, CLK_DIV=1 -> all outputs at reset values during reset. First edge after release gives count_rgb=0, reset_count_rgb=0, frame_start=1, video_active=1, pix_en=1. frame_start=0 on the next edge.
- Run one line -> hsync active exactly for count_rgb 840..967 (128 ticks). video_active falls when count_rgb=800. After 1055, count_rgb=0 and reset_count_rgb=1.
- Run a full frame -> vsync active for lines 601..604 only. After (1055,627), the next position is (0,0) with frame_start=1. Exactly 1056*628=663168 ticks between frame_start pulses.
- CLK_DIV=2 -> pix_en alternates 0/1, outputs change only on edges where pix_en becomes 1, and frame period = 1326336 clk.
- Assert rst_n=0 at position (500,300) for one edge -> next state equals the reset values. After release, sequence restarts at (0,0) with frame_start.
- HS_POL=0, VS_POL=0 -> hsync/vsync idle high, low during the same windows; reset value is high.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, output record and parameter-derivation helpers
// for the 800x600@60 raster generator.
package vga_timing_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  localparam int   DEF_CLK_DIV = 1;
  localparam int   DEF_H_VIS   = 800;
  localparam int   DEF_H_FP    = 40;
  localparam int   DEF_H_SYNC  = 128;
  localparam int   DEF_H_BP    = 88;
  localparam int   DEF_V_VIS   = 600;
  localparam int   DEF_V_FP    = 1;
  localparam int   DEF_V_SYNC  = 4;
  localparam int   DEF_V_BP    = 23;
  localparam logic DEF_HS_POL  = 1'b1;
  localparam logic DEF_VS_POL  = 1'b1;

  localparam int DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Everything the pixel-fetch stage sees changes together in one record.
  typedef struct packed {
    logic [HCNT_W-1:0] h;
    logic [VCNT_W-1:0] v;
    logic              hsync;
    logic              vsync;
    logic              active;
    logic              frame_start;
  } timing_t;

  function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int vis, input int fp);
    return vis + fp;
  endfunction

  function automatic int sync_end(input int vis, input int fp, input int sync);
    return vis + fp + sync - 1;
  endfunction

  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with enable; wrap flags the terminal count (MOD-1).
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = cnt_width(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  if (MOD < 1) begin : g_bad_mod
    $error("mod_counter: MOD must be >= 1");
  end

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: position counters plus registered sync/active
// decode, all updating together on each pixel tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV = DEF_CLK_DIV,
  parameter int   H_VIS   = DEF_H_VIS,
  parameter int   H_FP    = DEF_H_FP,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BP    = DEF_H_BP,
  parameter int   V_VIS   = DEF_V_VIS,
  parameter int   V_FP    = DEF_V_FP,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BP    = DEF_V_BP,
  parameter logic HS_POL  = DEF_HS_POL,
  parameter logic VS_POL  = DEF_VS_POL
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [HCNT_W-1:0] count_rgb,
  output logic [VCNT_W-1:0] reset_count_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              video_active,
  output logic              frame_start,
  output logic              pix_en
);

  localparam int H_TOT = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int DIV_W = cnt_width(CLK_DIV);

  localparam logic [HCNT_W-1:0] HS_START = HCNT_W'(sync_start(H_VIS, H_FP));
  localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(sync_end(H_VIS, H_FP, H_SYNC));
  localparam logic [HCNT_W-1:0] H_VIS_C  = HCNT_W'(H_VIS);
  localparam logic [VCNT_W-1:0] VS_START = VCNT_W'(sync_start(V_VIS, V_FP));
  localparam logic [VCNT_W-1:0] VS_END   = VCNT_W'(sync_end(V_VIS, V_FP, V_SYNC));
  localparam logic [VCNT_W-1:0] V_VIS_C  = VCNT_W'(V_VIS);

  if (H_TOT > (1 << HCNT_W)) begin : g_bad_htot
    $error("vga_timing_gen: H_TOT exceeds 2048");
  end
  if (V_TOT > (1 << VCNT_W)) begin : g_bad_vtot
    $error("vga_timing_gen: V_TOT exceeds 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0]  d_cnt;
  logic              tick;
  logic [HCNT_W-1:0] h_nxt;
  logic              h_wrap;
  logic [VCNT_W-1:0] v_nxt;
  logic              v_wrap;

  mod_counter #(.MOD(CLK_DIV), .W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .cnt   (d_cnt),
    .wrap  (tick)
  );

  mod_counter #(.MOD(H_TOT), .W(HCNT_W)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick),
    .cnt   (h_nxt),
    .wrap  (h_wrap)
  );

  // Lines advance only on the tick that retires the last pixel of a line.
  mod_counter #(.MOD(V_TOT), .W(VCNT_W)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_wrap & tick),
    .cnt   (v_nxt),
    .wrap  (v_wrap)
  );

  logic unused_sig;
  assign unused_sig = ^{d_cnt, v_wrap};

  timing_t timing_q;
  timing_t timing_d;
  logic    pix_en_q;
  logic    pix_en_d;

  always_comb begin
    timing_d = timing_q;
    pix_en_d = tick;
    if (tick) begin
      timing_d.h           = h_nxt;
      timing_d.v           = v_nxt;
      timing_d.hsync       = ((h_nxt >= HS_START) && (h_nxt <= HS_END)) ? HS_POL : ~HS_POL;
      timing_d.vsync       = ((v_nxt >= VS_START) && (v_nxt <= VS_END)) ? VS_POL : ~VS_POL;
      timing_d.active      = (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
      timing_d.frame_start = (h_nxt == '0) && (v_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timing_q.h           <= '0;
      timing_q.v           <= '0;
      timing_q.hsync       <= ~HS_POL;
      timing_q.vsync       <= ~VS_POL;
      timing_q.active      <= 1'b0;
      timing_q.frame_start <= 1'b0;
      pix_en_q             <= 1'b0;
    end else begin
      timing_q <= timing_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign count_rgb       = timing_q.h;
  assign reset_count_rgb = timing_q.v;
  assign hsync           = timing_q.hsync;
  assign vsync           = timing_q.vsync;
  assign video_active    = timing_q.active;
  assign frame_start     = timing_q.frame_start;
  assign pix_en          = pix_en_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 instance plus two reduced-timing instances
// (CLK_DIV=1 positive sync, CLK_DIV=2 negative sync) for frame-level corners.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n, rst2_n;
  logic [10:0] h0, h1, h2;
  logic [9:0]  v0, v1, v2;
  logic        hs0, vs0, va0, fs0, pe0;
  logic        hs1, vs1, va1, fs1, pe1;
  logic        hs2, vs2, va2, fs2, pe2;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst0_n), .count_rgb(h0), .reset_count_rgb(v0),
    .hsync(hs0), .vsync(vs0), .video_active(va0), .frame_start(fs0), .pix_en(pe0)
  );

  // Small raster: H 8+2+3+2=15 (hsync 10..12), V 4+1+2+1=8 (vsync 5..6).
  vga_timing_gen #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .count_rgb(h1), .reset_count_rgb(v1),
    .hsync(hs1), .vsync(vs1), .video_active(va1), .frame_start(fs1), .pix_en(pe1)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .count_rgb(h2), .reset_count_rgb(v2),
    .hsync(hs2), .vsync(vs2), .video_active(va2), .frame_start(fs2), .pix_en(pe2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // k = clk edges since reset release; outputs then show pixel k-1.
  typedef struct {
    int          k;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, va, fs, pe;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cur;
    int hs_cnt, va_cnt, vs_cnt, fs_cnt, first_hs, vs_glitch, vs_min, vs_max;
    int pe_err, hold_err, period;
    logic prev_vs;
    logic [10:0] last_h;
    logic [9:0]  last_v;
    logic [25:0] prev_out;

    tbl[0]  = '{1,    11'd0,    10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,    11'd1,    10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{800,  11'd799,  10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{801,  11'd800,  10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{840,  11'd839,  10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{841,  11'd840,  10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{968,  11'd967,  10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{969,  11'd968,  10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1056, 11'd1055, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1057, 11'd0,    10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1857, 11'd800,  10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{2113, 11'd0,    10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    step(5);
    check("dut0 reset", {h0, v0, hs0, vs0, va0, fs0, pe0}, {11'd0, 10'd0, 5'b00000});
    check("dut2 reset neg pol", {h2, v2, hs2, vs2, va2, fs2, pe2}, {11'd0, 10'd0, 5'b11000});

    // Default raster: table of positions along the first lines.
    rst0_n = 1'b1;
    cur = 0;
    foreach (tbl[i]) begin
      step(tbl[i].k - cur);
      cur = tbl[i].k;
      check($sformatf("vec k=%0d", tbl[i].k),
            {h0, v0, hs0, vs0, va0, fs0, pe0},
            {tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].va, tbl[i].fs, tbl[i].pe});
    end

    // Scan line 2 in full.
    hs_cnt = 0; va_cnt = 0; first_hs = -1;
    for (int i = 0; i < 1056; i++) begin
      if (hs0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(h0);
      end
      if (va0) va_cnt++;
      step(1);
    end
    check("line hsync ticks", hs_cnt, 128);
    check("line first hsync h", first_hs, 840);
    check("line active ticks", va_cnt, 800);
    check("line wrap to (0,3)", {h0, v0}, {11'd0, 10'd3});

    // Mid-frame reset at (500,3).
    step(500);
    check("pre-reset pos", {h0, v0}, {11'd500, 10'd3});
    rst0_n = 1'b0;
    step(1);
    check("mid reset values", {h0, v0, hs0, vs0, va0, fs0, pe0}, {11'd0, 10'd0, 5'b00000});
    rst0_n = 1'b1;
    step(1);
    check("restart (0,0)", {h0, v0, hs0, vs0, va0, fs0, pe0}, {11'd0, 10'd0, 5'b00111});
    step(1);
    check("restart fs drop", {h0, v0, fs0}, {11'd1, 10'd0, 1'b0});

    // Small raster, CLK_DIV=1: one whole frame from the first tick.
    rst1_n = 1'b1;
    step(1);
    vs_cnt = 0; va_cnt = 0; hs_cnt = 0; fs_cnt = 0; vs_glitch = 0;
    vs_min = 99; vs_max = -1; prev_vs = vs1; last_h = '0; last_v = '0;
    for (int i = 0; i < 120; i++) begin
      if (vs1) begin
        vs_cnt++;
        if (int'(v1) < vs_min) vs_min = int'(v1);
        if (int'(v1) > vs_max) vs_max = int'(v1);
      end
      if (vs1 !== prev_vs && h1 != 11'd0) vs_glitch++;
      prev_vs = vs1;
      if (va1) va_cnt++;
      if (hs1) hs_cnt++;
      if (fs1) fs_cnt++;
      last_h = h1;
      last_v = v1;
      step(1);
    end
    check("frame vsync ticks", vs_cnt, 30);
    check("frame vsync first line", vs_min, 5);
    check("frame vsync last line", vs_max, 6);
    check("vsync off line edge", vs_glitch, 0);
    check("frame active ticks", va_cnt, 32);
    check("frame hsync ticks", hs_cnt, 24);
    check("frame fs pulses", fs_cnt, 1);
    check("frame last pos", {last_h, last_v}, {11'd14, 10'd7});
    check("frame wrap (0,0)", {h1, v1, fs1, va1}, {11'd0, 10'd0, 2'b11});

    // Frame period: bounded search for the next frame_start.
    period = -1;
    for (int i = 1; i <= 200; i++) begin
      step(1);
      if (fs1) begin
        period = i;
        break;
      end
    end
    check("frame period ticks", period, 120);

    // Small raster, CLK_DIV=2, negative sync polarity.
    rst2_n = 1'b1;
    step(1);
    check("div2 edge1", {h2, v2, hs2, vs2, va2, fs2, pe2}, {11'd0, 10'd0, 5'b11000});
    step(1);
    check("div2 first tick", {h2, v2, hs2, vs2, va2, fs2, pe2}, {11'd0, 10'd0, 5'b11111});
    pe_err = 0; hold_err = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    prev_out = {h2, v2, hs2, vs2, va2, fs2};
    for (int e = 0; e < 240; e++) begin
      if (pe2 !== ((e % 2) == 0)) pe_err++;
      if (!pe2 && ({h2, v2, hs2, vs2, va2, fs2} !== prev_out)) hold_err++;
      prev_out = {h2, v2, hs2, vs2, va2, fs2};
      if (pe2) begin
        if (!hs2) hs_cnt++;
        if (!vs2) vs_cnt++;
        if (fs2) fs_cnt++;
      end
      step(1);
    end
    check("div2 pix_en alternates", pe_err, 0);
    check("div2 hold without tick", hold_err, 0);
    check("div2 hsync low ticks", hs_cnt, 24);
    check("div2 vsync low ticks", vs_cnt, 30);
    check("div2 fs pulses", fs_cnt, 1);
    check("div2 frame at 240 clk", {h2, v2, fs2, pe2}, {11'd0, 10'd0, 2'b11});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
